div_iter_16bit: RTL and testbench

Iterative restoring divider, the inverse companion of the pipelined 8-bit multiplier in the arithmetic datapath. It accepts a 2·size-bit dividend and a size-bit divisor with a one-cycle enable. One quotient bit is produced per clock. Quotient and remainder are presented with a one-cycle output strobe. Divide-by-zero is flagged, never stalls.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 35 +++
 rtl/div_iter_16bit.sv | 152 +++++++++++++++
 tb/tb_div_iter_16bit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: operand widths,
// FSM state encoding and the divide-by-zero quotient pattern.
package div_pkg;

    localparam int DIV_SIZE  = 8;
    localparam int DIV_QW    = 2 * DIV_SIZE;
    localparam int DIV_CNT_W = $clog2(DIV_QW) + 1;

    // Counter value seen during the final iteration cycle
    localparam logic [DIV_CNT_W-1:0] DIV_LAST_ITER = DIV_CNT_W'(DIV_QW - 1);
    localparam logic [DIV_CNT_W-1:0] DIV_CNT_ONE   = DIV_CNT_W'(1);
    localparam logic [DIV_QW-1:0]    DIV_ZERO_QUOT = {DIV_QW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r,q} left, try subtracting d,
// keep the difference and set the quotient bit when it does not go negative.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_SIZE:0]   i_r,
    input  logic [DIV_QW-1:0]   i_q,
    input  logic [DIV_SIZE-1:0] i_d,
    output logic [DIV_SIZE:0]   o_r,
    output logic [DIV_QW-1:0]   o_q
);

    logic [DIV_SIZE:0] w_r_sh;
    logic [DIV_SIZE:0] w_diff;
    logic              w_ge;

    assign w_r_sh = {i_r[DIV_SIZE-1:0], i_q[DIV_QW-1]};
    assign w_diff = w_r_sh - {1'b0, i_d};
    // A set top bit of r means the shifted value overflowed r and certainly exceeds d
    assign w_ge   = i_r[DIV_SIZE] | (w_r_sh >= {1'b0, i_d});

    // Select restored or subtracted partial remainder and the new quotient bit
    always_comb begin
        o_r = w_r_sh;
        o_q = {i_q[DIV_QW-2:0], 1'b0};
        if (w_ge) begin
            o_r = w_diff;
            o_q = {i_q[DIV_QW-2:0], 1'b1};
        end else begin
            o_r = w_r_sh;
            o_q = {i_q[DIV_QW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter_16bit.sv
// Iterative 16-by-8 unsigned restoring divider: one quotient bit per clock,
// results presented for a single cycle with div_en_out, divide-by-zero flagged.
module div_iter_16bit
    import div_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                div_en_in,
    input  logic [DIV_QW-1:0]   dividend,
    input  logic [DIV_SIZE-1:0] divisor,
    output logic                busy,
    output logic                div_en_out,
    output logic [DIV_QW-1:0]   quotient,
    output logic [DIV_SIZE-1:0] remainder,
    output logic                div_by_zero
);

    div_state_t             r_state;
    div_state_t             w_state_nxt;
    logic [DIV_QW-1:0]      r_q;
    logic [DIV_SIZE:0]      r_r;
    logic [DIV_SIZE-1:0]    r_d;
    logic [DIV_CNT_W-1:0]   r_cnt;
    logic                   r_zero;
    logic [DIV_QW-1:0]      w_q_step;
    logic [DIV_SIZE:0]      w_r_step;
    logic                   w_accept;
    logic                   w_busy_nxt;
    logic                   w_en_nxt;
    logic [DIV_QW-1:0]      w_quot_nxt;
    logic [DIV_SIZE-1:0]    w_rem_nxt;
    logic                   w_dbz_nxt;
    logic                   r_busy;
    logic                   r_en_out;
    logic [DIV_QW-1:0]      r_quot;
    logic [DIV_SIZE-1:0]    r_rem;
    logic                   r_dbz;

    assign w_accept = (r_state == IDLE) && div_en_in;

    div_step u_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_d (r_d),
        .o_r (w_r_step),
        .o_q (w_q_step)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (divisor != {DIV_SIZE{1'b0}}) ? BUSY : DONE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (r_cnt == DIV_LAST_ITER) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM output decode; results are registered, so they appear the cycle after DONE
    always_comb begin
        w_busy_nxt = (w_state_nxt == BUSY);
        w_en_nxt   = 1'b0;
        w_quot_nxt = {DIV_QW{1'b0}};
        w_rem_nxt  = {DIV_SIZE{1'b0}};
        w_dbz_nxt  = 1'b0;
        if (r_state == DONE) begin
            w_en_nxt   = 1'b1;
            w_quot_nxt = r_zero ? DIV_ZERO_QUOT : r_q;
            w_rem_nxt  = r_zero ? r_q[DIV_SIZE-1:0] : r_r[DIV_SIZE-1:0];
            w_dbz_nxt  = r_zero;
        end else begin
            w_en_nxt   = 1'b0;
        end
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= {DIV_QW{1'b0}};
            r_r    <= {(DIV_SIZE+1){1'b0}};
            r_d    <= {DIV_SIZE{1'b0}};
            r_cnt  <= {DIV_CNT_W{1'b0}};
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_q    <= dividend;
                        r_d    <= divisor;
                        r_r    <= {(DIV_SIZE+1){1'b0}};
                        r_cnt  <= {DIV_CNT_W{1'b0}};
                        r_zero <= (divisor == {DIV_SIZE{1'b0}});
                    end
                end
                BUSY: begin
                    r_q   <= w_q_step;
                    r_r   <= w_r_step;
                    r_cnt <= r_cnt + DIV_CNT_ONE;
                end
                default: begin
                    r_q <= r_q;
                end
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_en_out <= 1'b0;
            r_quot   <= {DIV_QW{1'b0}};
            r_rem    <= {DIV_SIZE{1'b0}};
            r_dbz    <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_en_out <= w_en_nxt;
            r_quot   <= w_quot_nxt;
            r_rem    <= w_rem_nxt;
            r_dbz    <= w_dbz_nxt;
        end
    end

    assign busy        = r_busy;
    assign div_en_out  = r_en_out;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_iter_16bit.sv
// Directed self-checking bench for div_iter_16bit with hand-computed results.
module tb_div_iter_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_en_in;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        div_en_out;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int pass_cnt = 0;
    int total_cnt = 0;

    div_iter_16bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_en_in   (div_en_in),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .div_en_out  (div_en_out),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Present one request for a single cycle; returns at the negedge after the accept edge
    task automatic issue(input logic [15:0] dd, input logic [7:0] dv);
        @(negedge clk);
        dividend  = dd;
        divisor   = dv;
        div_en_in = 1'b1;
        @(negedge clk);
        div_en_in = 1'b0;
    endtask

    // Count edges after the accept edge until the strobe is seen (bounded)
    task automatic wait_strobe(output int lat);
        lat = 0;
        while (!div_en_out && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; div_en_in = 1'b0; dividend = 16'd0; divisor = 8'd0;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (div_en_out !== 1'b0) $display("FAIL reset_en_out: got %0b want 0", div_en_out); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd0) $display("FAIL reset_quotient: got %0d want 0", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 8'd0) $display("FAIL reset_remainder: got %0d want 0", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %0b want 0", div_by_zero); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat;
        issue(16'd200, 8'd7);
        total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_high: got %0b want 1", busy); else pass_cnt++;
        wait_strobe(lat);
        total_cnt++; if (lat != 17) $display("FAIL basic_latency: got %0d want 17", lat); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd28) $display("FAIL basic_quotient: got %0d want 28", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 8'd4) $display("FAIL basic_remainder: got %0d want 4", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL basic_dbz: got %0b want 0", div_by_zero); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_low_at_strobe: got %0b want 0", busy); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (div_en_out !== 1'b0) $display("FAIL basic_strobe_one_cycle: got %0b want 0", div_en_out); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd0) $display("FAIL basic_quotient_cleared: got %0d want 0", quotient); else pass_cnt++;
    endtask

    task automatic test_max;
        int lat;
        issue(16'd65535, 8'd255);
        wait_strobe(lat);
        total_cnt++; if (lat != 17) $display("FAIL max255_latency: got %0d want 17", lat); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd257) $display("FAIL max255_quotient: got %0d want 257", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 8'd0) $display("FAIL max255_remainder: got %0d want 0", remainder); else pass_cnt++;
        issue(16'd65535, 8'd1);
        wait_strobe(lat);
        total_cnt++; if (lat != 17) $display("FAIL max1_latency: got %0d want 17", lat); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd65535) $display("FAIL max1_quotient: got %0d want 65535", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 8'd0) $display("FAIL max1_remainder: got %0d want 0", remainder); else pass_cnt++;
    endtask

    task automatic test_div_zero;
        int lat;
        issue(16'd1000, 8'd0);
        total_cnt++; if (busy !== 1'b0) $display("FAIL dz_busy: got %0b want 0", busy); else pass_cnt++;
        wait_strobe(lat);
        total_cnt++; if (lat != 1) $display("FAIL dz_latency: got %0d want 1", lat); else pass_cnt++;
        total_cnt++; if (quotient !== 16'hFFFF) $display("FAIL dz_quotient: got %0h want ffff", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 8'hE8) $display("FAIL dz_remainder: got %0h want e8", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b1) $display("FAIL dz_flag: got %0b want 1", div_by_zero); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL dz_flag_cleared: got %0b want 0", div_by_zero); else pass_cnt++;
    endtask

    task automatic test_busy_drop;
        int lat;
        int n;
        issue(16'd1000, 8'd3);
        lat = 0;
        while (!div_en_out && lat < 40) begin
            if (lat == 5) begin
                total_cnt++; if (busy !== 1'b1) $display("FAIL drop_busy_mid: got %0b want 1", busy); else pass_cnt++;
                dividend = 16'd50; divisor = 8'd5; div_en_in = 1'b1;
            end else if (lat == 16) begin
                total_cnt++; if (busy !== 1'b0) $display("FAIL drop_busy_done: got %0b want 0", busy); else pass_cnt++;
                dividend = 16'd50; divisor = 8'd5; div_en_in = 1'b1;
            end else begin
                div_en_in = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        div_en_in = 1'b0;
        total_cnt++; if (lat != 17) $display("FAIL drop_latency: got %0d want 17", lat); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd333) $display("FAIL drop_quotient: got %0d want 333", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 8'd1) $display("FAIL drop_remainder: got %0d want 1", remainder); else pass_cnt++;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_en_out) n++;
        end
        total_cnt++; if (n != 0) $display("FAIL drop_extra_strobes: got %0d want 0", n); else pass_cnt++;
    endtask

    task automatic test_reset_abort;
        int lat;
        int n;
        issue(16'd200, 8'd7);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if ({div_en_out, quotient, remainder, div_by_zero} !== 26'd0)
            $display("FAIL abort_outputs: got %0h want 0", {div_en_out, quotient, remainder, div_by_zero}); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (div_en_out) n++;
        end
        total_cnt++; if (n != 0) $display("FAIL abort_no_strobe: got %0d want 0", n); else pass_cnt++;
        issue(16'd9, 8'd2);
        wait_strobe(lat);
        total_cnt++; if (lat != 17) $display("FAIL abort_next_latency: got %0d want 17", lat); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd4) $display("FAIL abort_next_quotient: got %0d want 4", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 8'd1) $display("FAIL abort_next_remainder: got %0d want 1", remainder); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat;
        int gap;
        issue(16'd6, 8'd3);
        wait_strobe(lat);
        total_cnt++; if (lat != 17) $display("FAIL b2b_first_latency: got %0d want 17", lat); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd2) $display("FAIL b2b_first_quotient: got %0d want 2", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 8'd0) $display("FAIL b2b_first_remainder: got %0d want 0", remainder); else pass_cnt++;
        dividend = 16'd7; divisor = 8'd7; div_en_in = 1'b1;
        @(negedge clk);
        div_en_in = 1'b0;
        gap = 1;
        while (!div_en_out && gap < 60) begin
            @(negedge clk);
            gap++;
        end
        total_cnt++; if (gap != 18) $display("FAIL b2b_strobe_spacing: got %0d want 18", gap); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd1) $display("FAIL b2b_second_quotient: got %0d want 1", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 8'd0) $display("FAIL b2b_second_remainder: got %0d want 0", remainder); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_div_zero();
        test_busy_drop();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
